// File: rtl/uart_bus_responder.sv
// uart_bus_responder
//   Byte-wide host bus front end for an 8N1 UART. The host writes a byte into
//   the transmit holding register (THR) with a wrn pulse. The transmitter
//   serialises that byte on txd. Received serial bytes land in the receive
//   buffer register (RBR). The host reads the RBR by pulling rdn low.
//
//   Optional feature (macro UART_LOOPBACK_EN): the receiver listens to the
//   internal txd signal instead of the rxd pin. The txd pin is still driven.
//
// Parameters
//   CLKS_PER_BIT : CLK cycles per serial bit (minimum 4)
// Ports
//   CLK        in    system clock, rising edge
//   RST        in    asynchronous reset, active-low
//   data[7:0]  inout host bus; carries RBR while rdn=0, otherwise high-Z
//   rdn        in    active-low read strobe
//   wrn        in    active-low write strobe; data captured when it ends
//   data_ready out   RBR holds an unread byte
//   tbre       out   THR empty
//   tsre       out   transmit shifter idle, line at stop level
//   rxd        in    serial receive line, idle high
//   txd        out   serial transmit line, idle high
module uart_bus_responder #(
  parameter int CLKS_PER_BIT = 96
) (
  input  logic       CLK,
  input  logic       RST,
  inout  wire  [7:0] data,
  input  logic       rdn,
  input  logic       wrn,
  output logic       data_ready,
  output logic       tbre,
  output logic       tsre,
  input  logic       rxd,
  output logic       txd
);

  localparam int DATA_W = 8;
  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic rx_src;
  logic rdn_p0, rdn_p1, rdn_p2;
  logic wrn_p0, wrn_p1, wrn_p2;
  logic rxd_p0, rxd_p1, rxd_p2;
  logic wr_evt, rd_evt, rx_fall;

  tx_state_t         tx_state, tx_state_nx;
  logic [CNT_W-1:0]  tx_cnt, tx_cnt_nx;
  logic [2:0]        tx_idx, tx_idx_nx;
  logic [DATA_W-1:0] tx_shift, tx_shift_nx;
  logic [DATA_W-1:0] thr, thr_nx;
  logic              tbre_nx, tsre_nx, txd_nx;

  rx_state_t         rx_state, rx_state_nx;
  logic [CNT_W-1:0]  rx_cnt, rx_cnt_nx;
  logic [2:0]        rx_idx, rx_idx_nx;
  logic [DATA_W-1:0] rx_shift, rx_shift_nx;
  logic [DATA_W-1:0] rbr, rbr_nx;
  logic              dr_nx;

`ifdef UART_LOOPBACK_EN
  assign rx_src = txd;
`else
  assign rx_src = rxd;
`endif

  // Bus read path follows the raw strobe so the host sees data without delay.
  assign data = rdn ? {DATA_W{1'bz}} : rbr;

  // ---- stage p0/p1: two-flop synchronizers, p2: edge register ----
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      {rdn_p0, rdn_p1, rdn_p2} <= 3'b111;
      {wrn_p0, wrn_p1, wrn_p2} <= 3'b111;
      {rxd_p0, rxd_p1, rxd_p2} <= 3'b111;
    end else begin
      {rdn_p0, rdn_p1, rdn_p2} <= {rdn,    rdn_p0, rdn_p1};
      {wrn_p0, wrn_p1, wrn_p2} <= {wrn,    wrn_p0, wrn_p1};
      {rxd_p0, rxd_p1, rxd_p2} <= {rx_src, rxd_p0, rxd_p1};
    end
  end

  assign wr_evt  = wrn_p1 & ~wrn_p2;
  assign rd_evt  = rdn_p1 & ~rdn_p2;
  assign rx_fall = ~rxd_p1 & rxd_p2;

  // ---- transmit path: THR capture and 8N1 serialiser ----
  always_comb begin
    tx_state_nx = tx_state;
    tx_cnt_nx   = tx_cnt;
    tx_idx_nx   = tx_idx;
    tx_shift_nx = tx_shift;
    thr_nx      = thr;
    tbre_nx     = tbre;
    tsre_nx     = tsre;
    txd_nx      = txd;

    // A write while THR is still full is dropped. This also covers a write
    // landing in the same cycle the shifter loads, because tbre is still 0.
    if (wr_evt && tbre) begin
      thr_nx  = data;
      tbre_nx = 1'b0;
    end

    case (tx_state)
      TX_IDLE: begin
        if (!tbre) begin
          tx_shift_nx = thr;
          tbre_nx     = 1'b1;
          tsre_nx     = 1'b0;
          txd_nx      = 1'b0;
          tx_cnt_nx   = '0;
          tx_state_nx = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_nx   = '0;
          tx_idx_nx   = 3'd0;
          txd_nx      = tx_shift[0];
          tx_shift_nx = {1'b0, tx_shift[DATA_W-1:1]};
          tx_state_nx = TX_DATA;
        end else begin
          tx_cnt_nx = tx_cnt + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_nx = '0;
          if (tx_idx == 3'd7) begin
            txd_nx      = 1'b1;
            tx_state_nx = TX_STOP;
          end else begin
            tx_idx_nx   = tx_idx + 3'd1;
            txd_nx      = tx_shift[0];
            tx_shift_nx = {1'b0, tx_shift[DATA_W-1:1]};
          end
        end else begin
          tx_cnt_nx = tx_cnt + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_nx = '0;
          if (!tbre) begin
            // Back-to-back: next start bit follows the stop bit directly.
            tx_shift_nx = thr;
            tbre_nx     = 1'b1;
            txd_nx      = 1'b0;
            tx_state_nx = TX_START;
          end else begin
            tsre_nx     = 1'b1;
            tx_state_nx = TX_IDLE;
          end
        end else begin
          tx_cnt_nx = tx_cnt + 1'b1;
        end
      end
      default: tx_state_nx = TX_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= 3'd0;
      tx_shift <= '0;
      thr      <= '0;
      tbre     <= 1'b1;
      tsre     <= 1'b1;
      txd      <= 1'b1;
    end else begin
      tx_state <= tx_state_nx;
      tx_cnt   <= tx_cnt_nx;
      tx_idx   <= tx_idx_nx;
      tx_shift <= tx_shift_nx;
      thr      <= thr_nx;
      tbre     <= tbre_nx;
      tsre     <= tsre_nx;
      txd      <= txd_nx;
    end
  end

  // ---- receive path: mid-bit sampler and RBR update ----
  always_comb begin
    rx_state_nx = rx_state;
    rx_cnt_nx   = rx_cnt;
    rx_idx_nx   = rx_idx;
    rx_shift_nx = rx_shift;
    rbr_nx      = rbr;
    dr_nx       = data_ready;

    if (rd_evt) dr_nx = 1'b0;

    case (rx_state)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_cnt_nx   = '0;
          rx_state_nx = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt == CNT_HALF) begin
          // Start bit must still be low at its midpoint, else it was a glitch.
          rx_cnt_nx = '0;
          rx_idx_nx = 3'd0;
          rx_state_nx = rxd_p1 ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_nx = rx_cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt == CNT_LAST) begin
          rx_cnt_nx   = '0;
          rx_shift_nx = {rxd_p1, rx_shift[DATA_W-1:1]};
          if (rx_idx == 3'd7) rx_state_nx = RX_STOP;
          else                rx_idx_nx   = rx_idx + 3'd1;
        end else begin
          rx_cnt_nx = rx_cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt == CNT_LAST) begin
          rx_cnt_nx   = '0;
          rx_state_nx = RX_IDLE;
          // Completion overrides a same-cycle read clear and overwrites
          // an unread byte.
          if (rxd_p1) begin
            rbr_nx = rx_shift;
            dr_nx  = 1'b1;
          end
        end else begin
          rx_cnt_nx = rx_cnt + 1'b1;
        end
      end
      default: rx_state_nx = RX_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_idx     <= 3'd0;
      rx_shift   <= '0;
      rbr        <= '0;
      data_ready <= 1'b0;
    end else begin
      rx_state   <= rx_state_nx;
      rx_cnt     <= rx_cnt_nx;
      rx_idx     <= rx_idx_nx;
      rx_shift   <= rx_shift_nx;
      rbr        <= rbr_nx;
      data_ready <= dr_nx;
    end
  end

endmodule

// File: tb/tb_uart_bus_responder.sv
// Self-checking bench for uart_bus_responder with CLKS_PER_BIT = 16.
// Build with +define+UART_LOOPBACK_EN to exercise the loopback receive path.
module tb_uart_bus_responder;

  localparam int CPB = 16;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       rdn = 1'b1;
  logic       wrn = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] tb_data = 8'h00;
  logic       tb_drv = 1'b0;
  wire  [7:0] data;
  logic       data_ready, tbre, tsre, txd;

  // Host side of the bus; pull-ups make a released bus read as 0xFF.
  assign data = tb_drv ? tb_data : 8'hzz;
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (data[g]);
  end

  uart_bus_responder #(.CLKS_PER_BIT(CPB)) dut (
    .CLK(CLK), .RST(RST), .data(data), .rdn(rdn), .wrn(wrn),
    .data_ready(data_ready), .tbre(tbre), .tsre(tsre), .rxd(rxd), .txd(txd)
  );

  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct { logic [7:0] b; logic [9:0] frame; } tx_vec_t;
  typedef struct { logic [7:0] b; logic stop; logic exp_dr; logic [7:0] exp_data; } rx_vec_t;
  tx_vec_t txv[4];
  rx_vec_t rxv[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic start_write(input logic [7:0] b);
    @(negedge CLK);
    tb_data = b; tb_drv = 1'b1; wrn = 1'b0;
    tick(2);
    wrn = 1'b1;
  endtask

  task automatic send_serial(input logic [7:0] b, input logic stop);
    @(negedge CLK);
    rxd = 1'b0; tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i]; tick(CPB);
    end
    rxd = stop; tick(CPB);
    rxd = 1'b1;
  endtask

  task automatic read_and_clear(input logic [7:0] exp, input string tag);
    int n;
    @(negedge CLK);
    rdn = 1'b0;
    tick(1);
    check({tag, "_read"}, data, exp);
    rdn = 1'b1;
    n = 0;
    while (data_ready !== 1'b0 && n < 10) begin tick(1); n++; end
    check({tag, "_clear_within3"}, (n <= 3), 1);
    check({tag, "_bus_released"}, data, 8'hFF);
  endtask

  // Waits for the write to be accepted, then walks the frame and times tsre.
  task automatic tx_frame(input logic [7:0] b, input logic [9:0] frame);
    int n;
    int rise_k;
    start_write(b);
    n = 0;
    while (tbre !== 1'b0 && n < 20) begin tick(1); n++; end
    check($sformatf("tx%02h_tbre_fall", b), tbre, 0);
    tb_drv = 1'b0;
    n = 0;
    while (tbre === 1'b0 && n < 10) begin tick(1); n++; end
    check($sformatf("tx%02h_tbre_low_cycles", b), n, 1);
    rise_k = -1;
    for (int k = 0; k < 200; k++) begin
      if (k < 160 && (k % 16) == 8)
        check($sformatf("tx%02h_bit%0d", b, k / 16), txd, frame[k / 16]);
      if (rise_k < 0 && tsre === 1'b1) rise_k = k;
      tick(1);
    end
    check($sformatf("tx%02h_tsre_rise", b), rise_k, 160);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int bad;
    logic [19:0] b2b;

    // Frame bits indexed by bit time: [0]=start, [8:1]=data LSB first, [9]=stop.
    txv[0] = '{8'hA5, 10'h34A};
    txv[1] = '{8'h00, 10'h200};
    txv[2] = '{8'hFF, 10'h3FE};
    txv[3] = '{8'h3C, 10'h278};
    rxv[0] = '{8'h3C, 1'b1, 1'b1, 8'h3C};
    rxv[1] = '{8'h81, 1'b0, 1'b0, 8'h00};
    rxv[2] = '{8'hA5, 1'b1, 1'b1, 8'hA5};
    rxv[3] = '{8'h00, 1'b1, 1'b1, 8'h00};

    // Reset state.
    tick(3);
    check("rst_txd", txd, 1);
    check("rst_tbre", tbre, 1);
    check("rst_tsre", tsre, 1);
    check("rst_data_ready", data_ready, 0);
    check("rst_bus_z", data, 8'hFF);
    RST = 1'b1;
    tick(3);

    // Single frames.
    for (int i = 0; i < 4; i++) tx_frame(txv[i].b, txv[i].frame);

    // Back-to-back frames; the third write arrives while THR is full.
    start_write(8'h55);
    n = 0;
    while (tbre !== 1'b0 && n < 20) begin tick(1); n++; end
    tb_drv = 1'b0;
    n = 0;
    while (tbre === 1'b0 && n < 10) begin tick(1); n++; end
    b2b = {10'h21E, 10'h2AA};
    bad = 0;
    fork
      begin
        start_write(8'h0F); tick(4); tb_drv = 1'b0;
        start_write(8'hEE); tick(4); tb_drv = 1'b0;
      end
      begin
        for (int k = 0; k < 320; k++) begin
          if (tsre !== 1'b0) bad++;
          if ((k % 16) == 8) check($sformatf("b2b_bit%0d", k / 16), txd, b2b[k / 16]);
          tick(1);
        end
      end
    join
    check("b2b_tsre_low_320", bad, 0);
    check("b2b_tsre_end", tsre, 1);
    tick(40);
    check("b2b_dropped_write_tbre", tbre, 1);
    check("b2b_dropped_write_tsre", tsre, 1);
    check("b2b_dropped_write_txd", txd, 1);

`ifndef UART_LOOPBACK_EN
    // Receive table.
    for (int i = 0; i < 4; i++) begin
      send_serial(rxv[i].b, rxv[i].stop);
      check($sformatf("rx%02h_data_ready", rxv[i].b), data_ready, rxv[i].exp_dr);
      if (rxv[i].exp_dr) read_and_clear(rxv[i].exp_data, $sformatf("rx%02h", rxv[i].b));
      tick(5);
    end

    // Short glitch is rejected, then overrun keeps the newest byte.
    @(negedge CLK);
    rxd = 1'b0; tick(4); rxd = 1'b1;
    tick(200);
    check("glitch_no_byte", data_ready, 0);
    send_serial(8'hA5, 1'b1);
    tick(5);
    send_serial(8'h5A, 1'b1);
    check("overrun_data_ready", data_ready, 1);
    read_and_clear(8'h5A, "overrun");
`else
    // Loopback: the transmitted byte comes back; rxd activity is ignored.
    start_write(8'h96);
    n = 0;
    while (tbre !== 1'b0 && n < 20) begin tick(1); n++; end
    tb_drv = 1'b0;
    for (int k = 0; k < 220; k++) begin
      rxd = ((k % 3) == 0);
      tick(1);
    end
    rxd = 1'b1;
    check("loop_data_ready", data_ready, 1);
    read_and_clear(8'h96, "loop");
`endif

    // Reset in the middle of a TX frame and an RX frame.
`ifndef UART_LOOPBACK_EN
    send_serial(8'hC3, 1'b1);
    check("pre_reset_data_ready", data_ready, 1);
`endif
    start_write(8'h00);
    n = 0;
    while (tbre !== 1'b0 && n < 20) begin tick(1); n++; end
    tb_drv = 1'b0;
    fork
      send_serial(8'h77, 1'b1);
      begin
        tick(40);
        check("pre_reset_txd_low", txd, 0);
        #2 RST = 1'b0;
        #1;
        check("mid_rst_txd", txd, 1);
        check("mid_rst_tbre", tbre, 1);
        check("mid_rst_tsre", tsre, 1);
        check("mid_rst_data_ready", data_ready, 0);
        check("mid_rst_bus_z", data, 8'hFF);
        rdn = 1'b0;
        #1;
        check("mid_rst_read_zero", data, 8'h00);
        rdn = 1'b1;
      end
    join
    @(negedge CLK);
    RST = 1'b1;
    tick(200);
    check("post_rst_no_byte", data_ready, 0);
    check("post_rst_tsre", tsre, 1);
    check("post_rst_txd", txd, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_bus_responder.md
UART_BUS_RESPONDER -- requirements
Module: uart_bus_responder

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 96, CLK cycles per serial bit (11.0592 MHz / 115200); legal minimum 4.
REQ-002 SHALL have port CLK  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port data  inout  8  shared bus; driven with RBR while rdn=0, else high-Z.
REQ-005 SHALL have port rdn  input  1  active-low read strobe from host.
REQ-006 SHALL have port wrn  input  1  active-low write strobe from host; data captured at end of strobe.
REQ-007 SHALL have port data_ready  output  1  receive buffer register (RBR) holds an unread byte.
REQ-008 SHALL have port tbre  output  1  transmit holding register (THR) empty.
REQ-009 SHALL have port tsre  output  1  transmit shifter idle, line at stop level.
REQ-010 SHALL have port rxd  input  1  serial receive line, idle high.
REQ-011 SHALL have port txd  output  1  serial transmit line, idle high.

Function
REQ-012 SHALL pass rdn, wrn, rxd through 2-flop synchronizers (reset value 1), then an edge register.
REQ-013 SHALL raise write event in the cycle synchronized wrn goes 0->1; capture data into THR, tbre<=0 on that edge (3rd CLK edge after pad rise).
REQ-014 SHALL drop a write event arriving while tbre=0; THR unchanged.
REQ-015 SHALL drive data combinationally from raw rdn: rdn=0 -> RBR, else Z; rdn=0 and wrn=0 together -> drive, write still captured.
REQ-016 SHALL clear data_ready on synchronized rdn 0->1 event.
REQ-017 TX FSM states TX_IDLE, TX_START, TX_DATA, TX_STOP; frame 8N1, LSB first, each bit exactly CLKS_PER_BIT cycles.
REQ-018 TX_IDLE with tbre=0: load shifter from THR, tbre<=1, tsre<=0, txd<=0, enter TX_START (txd falls 1 cycle after tbre falls).
REQ-019 TX_START -> TX_DATA after CLKS_PER_BIT; TX_DATA shifts 8 bits -> TX_STOP; TX_STOP txd=1 for CLKS_PER_BIT.
REQ-020 TX_STOP end: tbre=0 -> reload and enter TX_START with no idle gap, tsre stays 0; else TX_IDLE, tsre<=1.
REQ-021 Write event in same cycle as THR->shifter load SHALL be dropped per REQ-014 (tbre still 0 that cycle).
REQ-022 RX FSM states RX_IDLE, RX_START, RX_DATA, RX_STOP; RX_IDLE -> RX_START on synchronized rxd 1->0.
REQ-023 RX_START samples at CLKS_PER_BIT/2: rxd=0 -> RX_DATA; rxd=1 -> RX_IDLE (glitch reject).
REQ-024 RX_DATA samples 8 bits at CLKS_PER_BIT intervals from start midpoint, LSB first; RX_STOP samples one further interval later.
REQ-025 Stop sample 1: RBR<=byte, data_ready<=1; stop sample 0 (framing error): byte discarded, data_ready unchanged; both -> RX_IDLE.
REQ-026 Byte completion with data_ready=1 SHALL overwrite RBR (overrun), data_ready stays 1.
REQ-027 Byte completion and read-clear event in same cycle: completion wins, data_ready=1.
REQ-028 Bit counters SHALL count 0..CLKS_PER_BIT-1 and wrap; bit index 0..7, no wrap past 7.

Reset
REQ-029 RST=0 SHALL immediately force: txd=1, tbre=1, tsre=1, data_ready=0, RBR=THR=0x00, both FSMs idle, counters 0, synchronizers 1.
REQ-030 Reset mid-frame SHALL abort TX/RX with no partial byte delivered; data high-Z unless rdn=0 (drives 0x00).

Configuration
REQ-031 With UART_LOOPBACK_EN defined, RX path SHALL take the internal txd signal instead of rxd; rxd ignored; txd pin still driven.
REQ-032 Without UART_LOOPBACK_EN, RX path SHALL use rxd pin; no loopback logic present.

Verification (bench CLKS_PER_BIT=16)
REQ-033 Assert RST=0 mid-frame -> txd=1, tbre=1, tsre=1, data_ready=0, data=Z same cycle.
REQ-034 data=0xA5, wrn pulse -> tbre=0 one cycle; txd 0,1,0,1,0,0,1,0,1,1 each 16 cycles; tsre=1 160 cycles after start bit.
REQ-035 Write 0x55, then 0x0F once tbre=1 -> second start bit immediately after first stop; tsre=0 for 320 cycles continuous.
REQ-036 Serial 0x3C on rxd -> data_ready=1 after stop sample; rdn=0 -> data=0x3C; rdn rise -> data_ready=0 within 3 cycles.
REQ-037 Frame 0x81 with stop=0 -> data_ready stays 0; rxd low 4 cycles only -> RX_IDLE, no byte.
REQ-038 UART_LOOPBACK_EN defined, write 0x96 -> data_ready=1 after frame; read returns 0x96; rxd toggling ignored.
